// File: rtl/bitty_wb_sequencer_if.sv
// Wishbone slave bus bundle for the Bitty sequencer (32-bit data, byte address).
interface bitty_wb_sequencer_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/bitty_wb_sequencer.sv
// Bitty core sequencer: firmware queues instructions over Wishbone, an FSM issues
// them one at a time on the run/instr/done handshake, results are buffered for
// read-back and the latest one is driven on the IOs.
module bitty_wb_sequencer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  bitty_wb_sequencer_if.slave wbs,
  output logic              core_run,
  output logic [DATA_W-1:0] core_instr,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic [DATA_W-1:0] io_out,
  output logic [DATA_W-1:0] io_oeb,
  output logic [2:0]        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_INSTR  = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  // Register state
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              enable_q, enable_d, irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, tmo_flag_q, tmo_flag_d;
  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d, io_out_q, io_out_d;
  logic [AW-1:0]     ifq_wp_q, ifq_wp_d, ifq_rp_q, ifq_rp_d;
  logic [AW-1:0]     rfq_wp_q, rfq_wp_d, rfq_rp_q, rfq_rp_d;
  logic [AW:0]       ifq_cnt_q, ifq_cnt_d, rfq_cnt_q, rfq_cnt_d;
  logic [DATA_W-1:0] ifq_mem_q [DEPTH];
  logic [DATA_W-1:0] rfq_mem_q [DEPTH];

  // Decoded strobes
  logic        req, wr, rd, clear;
  logic [1:0]  reg_sel;
  logic        ifq_empty, ifq_full, rfq_empty, rfq_full, busy;
  logic        ifq_push_req, ifq_push, ifq_pop;
  logic        rfq_pop_req, rfq_pop, rfq_push;
  logic [15:0] status;
  logic [31:0] rdata;
  logic        unused_bits;

  // Byte selects and undecoded address/data bits are don't-care (full-word access).
  assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i, wbs.wbs_dat_i};

  assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign wr      = req & wbs.wbs_we_i;
  assign rd      = req & ~wbs.wbs_we_i;
  assign reg_sel = wbs.wbs_adr_i[3:2];
  assign clear   = wr && (reg_sel == REG_CTRL) && wbs.wbs_dat_i[1];

  assign ifq_empty = (ifq_cnt_q == '0);
  assign ifq_full  = (ifq_cnt_q == FULL_CNT);
  assign rfq_empty = (rfq_cnt_q == '0);
  assign rfq_full  = (rfq_cnt_q == FULL_CNT);
  assign busy      = (state_q != S_IDLE);

  // Full/empty are judged on pre-edge state, so a same-edge FSM pop never rescues a push.
  assign ifq_push_req = wr && (reg_sel == REG_INSTR);
  assign ifq_push     = ifq_push_req & ~ifq_full;
  assign ifq_pop      = (state_q == S_ISSUE);
  assign rfq_pop_req  = rd && (reg_sel == REG_RESULT);
  assign rfq_pop      = rfq_pop_req & ~rfq_empty;
  assign rfq_push     = (state_q == S_WAIT) & core_done & ~rfq_full & ~clear;

  assign status = {8'(ifq_cnt_q), tmo_flag_q, udf_q, ovf_q, busy,
                   rfq_full, rfq_empty, ifq_full, ifq_empty};

  // Read-data mux; write-only and empty-FIFO reads return zero.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_CTRL:   rdata = {29'd0, irq_en_q, 1'b0, enable_q};
      REG_STATUS: rdata = {16'd0, status};
      REG_RESULT: rdata = rfq_empty ? '0 : 32'(rfq_mem_q[rfq_rp_q]);
      default:    rdata = '0;
    endcase
  end

  // Next-state logic for bus response, control, FIFO pointers and the issue FSM.
  // NOTE: every target gets a default at the top so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ack_d      = req;
    dat_d      = rd ? rdata : '0;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q | (ifq_push_req & ifq_full);
    udf_d      = udf_q | (rfq_pop_req & rfq_empty);
    tmo_flag_d = tmo_flag_q;
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    instr_d    = instr_q;
    io_out_d   = io_out_q;
    ifq_wp_d   = ifq_push ? ifq_wp_q + 1'b1 : ifq_wp_q;
    ifq_rp_d   = ifq_pop  ? ifq_rp_q + 1'b1 : ifq_rp_q;
    rfq_wp_d   = rfq_push ? rfq_wp_q + 1'b1 : rfq_wp_q;
    rfq_rp_d   = rfq_pop  ? rfq_rp_q + 1'b1 : rfq_rp_q;
    ifq_cnt_d  = ifq_cnt_q;
    rfq_cnt_d  = rfq_cnt_q;

    unique case ({ifq_push, ifq_pop})
      2'b10:   ifq_cnt_d = ifq_cnt_q + 1'b1;
      2'b01:   ifq_cnt_d = ifq_cnt_q - 1'b1;
      default: ifq_cnt_d = ifq_cnt_q;
    endcase
    unique case ({rfq_push, rfq_pop})
      2'b10:   rfq_cnt_d = rfq_cnt_q + 1'b1;
      2'b01:   rfq_cnt_d = rfq_cnt_q - 1'b1;
      default: rfq_cnt_d = rfq_cnt_q;
    endcase

    if (wr && (reg_sel == REG_CTRL)) begin
      enable_d = wbs.wbs_dat_i[0];
      irq_en_d = wbs.wbs_dat_i[2];
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable_q && !ifq_empty && !rfq_full) begin
          state_d = S_ISSUE;
          instr_d = ifq_mem_q[ifq_rp_q];
        end
      end
      S_ISSUE: begin
        state_d   = S_WAIT;
        tmo_cnt_d = '0;
      end
      S_WAIT: begin
        if (core_done) begin
          io_out_d = core_dout;
          state_d  = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear overrides everything above, including a result arriving on this edge.
    if (clear) begin
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      tmo_flag_d = 1'b0;
      state_d    = S_IDLE;
      io_out_d   = io_out_q;
      ifq_wp_d   = '0;
      ifq_rp_d   = '0;
      rfq_wp_d   = '0;
      rfq_rp_d   = '0;
      ifq_cnt_d  = '0;
      rfq_cnt_d  = '0;
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      state_q    <= S_IDLE;
      tmo_cnt_q  <= '0;
      instr_q    <= '0;
      io_out_q   <= '0;
      ifq_wp_q   <= '0;
      ifq_rp_q   <= '0;
      rfq_wp_q   <= '0;
      rfq_rp_q   <= '0;
      ifq_cnt_q  <= '0;
      rfq_cnt_q  <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      tmo_flag_q <= tmo_flag_d;
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      instr_q    <= instr_d;
      io_out_q   <= io_out_d;
      ifq_wp_q   <= ifq_wp_d;
      ifq_rp_q   <= ifq_rp_d;
      rfq_wp_q   <= rfq_wp_d;
      rfq_rp_q   <= rfq_rp_d;
      ifq_cnt_q  <= ifq_cnt_d;
      rfq_cnt_q  <= rfq_cnt_d;
    end
  end

  // FIFO storage writes.
  // NOTE: storage arrays are not reset; the counters and pointers define validity,
  // so stale entries are never observable.
  always_ff @(posedge wb_clk_i) begin
    if (ifq_push) ifq_mem_q[ifq_wp_q] <= wbs.wbs_dat_i[DATA_W-1:0];
    if (rfq_push) rfq_mem_q[rfq_wp_q] <= core_dout;
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign core_run      = (state_q == S_ISSUE);
  assign core_instr    = instr_q;
  assign io_out        = io_out_q;
  assign io_oeb        = {DATA_W{~enable_q}};
  assign irq           = {1'b0, irq_en_q & (ovf_q | udf_q | tmo_flag_q), irq_en_q & ~rfq_empty};
endmodule

// File: tb/tb_bitty_wb_sequencer.sv
// Self-checking bench for bitty_wb_sequencer: register-access vector table plus
// directed sequences for flow, overflow, backpressure, timeout and clear.
module tb_bitty_wb_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_run, core_done;
  logic [15:0] core_instr, core_dout, io_out, io_oeb;
  logic [2:0]  irq;

  bitty_wb_sequencer_if wb ();

  bitty_wb_sequencer #(.DATA_W(16), .DEPTH(8), .TIMEOUT(255)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs       (wb.slave),
    .core_run  (core_run),
    .core_instr(core_instr),
    .core_done (core_done),
    .core_dout (core_dout),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int ack_cyc  = 0;
  int last_lat = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Core model: records issues, answers with instr^0x5A5A after done_dly cycles.
  logic [15:0] issued[$];
  int          issue_cyc[$];
  bit          respond  = 1'b1;
  int          done_dly = 2;
  int          force_req = 0;
  int          force_seen = 0;
  int          dly = 0;
  logic [15:0] pend = '0;

  initial begin
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          core_done = 1'b1;
          core_dout = pend;
        end
      end
      if (force_req != force_seen) begin
        force_seen = force_req;
        core_done  = 1'b1;
        core_dout  = 16'hDEAD;
      end
      if (core_run === 1'b1) begin
        issued.push_back(core_instr);
        issue_cyc.push_back(cyc_n);
        if (respond) begin
          pend = core_instr ^ 16'h5A5A;
          dly  = done_dly;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone transfer; returns read data and leaves the bus idle with ack low.
  task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] wd,
                         output logic [31:0] rdat);
    int n;
    n = 0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = {28'd0, r, 2'b00};
    wb.wbs_dat_i = wd;
    do begin
      tick();
      n++;
    end while (wb.wbs_ack_o !== 1'b1 && n < 4);
    if (wb.wbs_ack_o !== 1'b1) check("wb_ack_timeout", {31'd0, wb.wbs_ack_o}, 32'd1);
    rdat     = wb.wbs_dat_o;
    last_lat = n;
    ack_cyc  = cyc_n;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    tick();
  endtask

  task automatic wr_reg(input logic [1:0] r, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, r, wd, dummy);
  endtask

  task automatic rd_check(input logic [1:0] r, input logic [31:0] exp, input string name);
    logic [31:0] v;
    wb_xfer(1'b0, r, 32'd0, v);
    check(name, v, exp);
  endtask

  task automatic wait_issues(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (issued.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, issued.size(), n);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  r;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [2:0]  exp_irq;
    string       name;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] v;
    tbl[0]  = '{1'b0, 2'd1, 32'h0,    32'h0005, 3'd0, "st_reset"};
    tbl[1]  = '{1'b1, 2'd0, 32'h4,    32'h0,    3'd0, "wr_ctrl_irqen"};
    tbl[2]  = '{1'b0, 2'd0, 32'h0,    32'h0004, 3'd0, "rd_ctrl"};
    tbl[3]  = '{1'b1, 2'd2, 32'h1111, 32'h0,    3'd0, "push_one"};
    tbl[4]  = '{1'b0, 2'd1, 32'h0,    32'h0104, 3'd0, "st_one"};
    tbl[5]  = '{1'b0, 2'd2, 32'h0,    32'h0,    3'd0, "rd_instr_wo"};
    tbl[6]  = '{1'b1, 2'd1, 32'hFFFF, 32'h0,    3'd0, "wr_status_ro"};
    tbl[7]  = '{1'b0, 2'd1, 32'h0,    32'h0104, 3'd0, "st_unchanged"};
    tbl[8]  = '{1'b0, 2'd3, 32'h0,    32'h0,    3'd2, "pop_empty"};
    tbl[9]  = '{1'b0, 2'd1, 32'h0,    32'h0144, 3'd2, "st_udf"};
    tbl[10] = '{1'b1, 2'd0, 32'h6,    32'h0,    3'd0, "wr_clear"};
    tbl[11] = '{1'b0, 2'd1, 32'h0,    32'h0005, 3'd0, "st_cleared"};
    tbl[12] = '{1'b0, 2'd0, 32'h0,    32'h0004, 3'd0, "rd_ctrl_clr0"};

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;

    // T1: reset values, then reset asserted in the middle of a transfer.
    repeat (3) tick();
    check("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    check("rst_dat", wb.wbs_dat_o, 32'd0);
    check("rst_oeb", {16'd0, io_oeb}, 32'hFFFF);
    check("rst_out", {15'd0, io_out, core_run}, 32'd0);
    check("rst_irq", {29'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick();
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_adr_i = 32'h4;
    tick();
    check("t1_ack_rise", {31'd0, wb.wbs_ack_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_ack_async_drop", {31'd0, wb.wbs_ack_o}, 32'd0);
    check("t1_oeb", {16'd0, io_oeb}, 32'hFFFF);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Register-access vector table.
    for (int i = 0; i < 13; i++) begin
      wb_xfer(tbl[i].we, tbl[i].r, tbl[i].wdata, v);
      check({tbl[i].name, "_data"}, v, tbl[i].exp_rd);
      check({tbl[i].name, "_lat"}, last_lat, 1);
      check({tbl[i].name, "_irq"}, {29'd0, irq}, {29'd0, tbl[i].exp_irq});
    end
    check("ack_one_cycle", {31'd0, wb.wbs_ack_o}, 32'd0);

    // T2: basic flow, done two cycles after each run.
    issued.delete();
    issue_cyc.delete();
    respond  = 1'b1;
    done_dly = 2;
    wr_reg(2'd2, 32'h1001);
    wr_reg(2'd2, 32'h2002);
    wr_reg(2'd2, 32'h3003);
    wr_reg(2'd0, 32'h5);
    wait_issues(3, 40, "t2_issues");
    repeat (4) tick();
    check("t2_order0", {16'd0, issued[0]}, 32'h1001);
    check("t2_order1", {16'd0, issued[1]}, 32'h2002);
    check("t2_order2", {16'd0, issued[2]}, 32'h3003);
    check("t2_spacing", issue_cyc[1] - issue_cyc[0], 4);
    check("t2_io_out", {16'd0, io_out}, {16'd0, 16'h3003 ^ 16'h5A5A});
    check("t2_oeb", {16'd0, io_oeb}, 32'h0);
    check("t2_instr_held", {16'd0, core_instr}, 32'h3003);
    check("t2_irq_avail", {29'd0, irq}, 32'd1);
    rd_check(2'd3, {16'd0, 16'h1001 ^ 16'h5A5A}, "t2_res0");
    rd_check(2'd3, {16'd0, 16'h2002 ^ 16'h5A5A}, "t2_res1");
    rd_check(2'd3, {16'd0, 16'h3003 ^ 16'h5A5A}, "t2_res2");
    rd_check(2'd1, 32'h0005, "t2_status");
    check("t2_irq_idle", {29'd0, irq}, 32'd0);

    // T3: overflow with enable low, then drain with the fastest core.
    wr_reg(2'd0, 32'h6);
    issued.delete();
    issue_cyc.delete();
    done_dly = 1;
    for (int i = 0; i < 9; i++) wr_reg(2'd2, 32'h0100 + i);
    rd_check(2'd1, 32'h0826, "t3_status_full");
    check("t3_irq_err", {29'd0, irq}, 32'd2);
    wr_reg(2'd0, 32'h5);
    wait_issues(8, 60, "t3_issues");
    repeat (6) tick();
    check("t3_ninth_dropped", issued.size(), 8);
    check("t3_first", {16'd0, issued[0]}, 32'h0100);
    check("t3_last", {16'd0, issued[7]}, 32'h0107);
    check("t3_min_spacing", issue_cyc[1] - issue_cyc[0], 3);

    // T4: result FIFO full stalls issue until one result is popped.
    wr_reg(2'd2, 32'h0200);
    repeat (10) tick();
    check("t4_stalled", issued.size(), 8);
    rd_check(2'd1, 32'h0128, "t4_status");
    check("t4_irq", {29'd0, irq}, 32'd3);
    rd_check(2'd3, {16'd0, 16'h0100 ^ 16'h5A5A}, "t4_pop");
    wait_issues(9, 10, "t4_resume");
    check("t4_resume_lat", ((issue_cyc[8] - ack_cyc) >= 1) && ((issue_cyc[8] - ack_cyc) <= 2), 1);
    check("t4_instr", {16'd0, issued[8]}, 32'h0200);
    repeat (3) tick();
    check("t4_io_out", {16'd0, io_out}, {16'd0, 16'h0200 ^ 16'h5A5A});

    // T5: core never answers; the wait aborts after 255 cycles.
    wr_reg(2'd0, 32'h6);
    respond = 1'b0;
    issued.delete();
    issue_cyc.delete();
    wr_reg(2'd2, 32'h0301);
    wr_reg(2'd2, 32'h0302);
    wr_reg(2'd0, 32'h5);
    wait_issues(2, 600, "t5_issues");
    check("t5_timeout_gap", issue_cyc[1] - issue_cyc[0], 257);
    check("t5_second", {16'd0, issued[1]}, 32'h0302);
    check("t5_instr_held", {16'd0, core_instr}, 32'h0302);
    rd_check(2'd1, 32'h0095, "t5_status");
    check("t5_irq", {29'd0, irq}, 32'd2);

    // T6: clear while waiting; a late done must not store anything.
    wr_reg(2'd0, 32'h3);
    force_req++;
    repeat (4) tick();
    rd_check(2'd1, 32'h0005, "t6_status");
    check("t6_irq", {29'd0, irq}, 32'd0);
    check("t6_io_out_kept", {16'd0, io_out}, {16'd0, 16'h0200 ^ 16'h5A5A});
    check("t6_oeb", {16'd0, io_oeb}, 32'h0);
    rd_check(2'd3, 32'h0, "t6_no_result");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
